// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side blocks.
//   UART_DATA_W : width of one UART byte
//   tx_state_e  : sequencing states of the transmit arbiter
//   clog2Min1() : $clog2 that never returns less than 1, used to size counters
//                 whose range can collapse to a single value
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    // A zero-width counter is not legal, so small ranges still get one bit.
    function automatic int clog2Min1(input int value);
        int width;
        width = $clog2(value);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one position past
// the previously granted index and wraps, so the last winner has the lowest
// priority on the next pick.
// Ports:
//   req_i   : request vector, one bit per requester
//   last_i  : index granted most recently
//   grant_o : one-hot grant (all zero when nothing requests)
//   index_o : binary index of the granted requester
//   any_o   : high when at least one requester is asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   index_o,
    output logic               any_o
);

    // Walk the candidates in priority order (last+1, last+2, ... wrapping) and
    // keep the first one that is requesting. Once any_o is set the remaining
    // candidates are skipped, which gives the first-set-bit behaviour.
    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        for (int offset = 1; offset <= NUM_REQ; offset++) begin
            cand = (int'(last_i) + offset) % NUM_REQ;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                index_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx serializer among NUM_REQ byte producers. Requesters are
// granted in round-robin order, the winning byte is latched, the transmitter
// is started with a one-cycle pulse, and the block then waits for the
// transmitter's done pulse before enforcing an idle gap. A watchdog drops the
// frame if done never arrives.
// Ports:
//   clk, rst_n  : clock (rising edge) and asynchronous active-low reset
//   i_req       : per-requester request, held with i_data stable until o_ack
//   i_data      : requester k byte at bits [8k+7:8k]
//   o_ack       : one-cycle pulse, byte of requester k accepted
//   o_tx_data   : byte presented to uart_tx, stable from START through WAIT
//   o_tx_start  : one-cycle start pulse to uart_tx
//   i_tx_done   : one-cycle pulse from uart_tx at end of stop bit
//   o_busy      : high in every state except IDLE
//   o_grant_id  : index of the current / last granted requester
//   o_timeout   : one-cycle pulse when the watchdog aborts a frame
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [UART_DATA_W*NUM_REQ-1:0] i_data,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic [UART_DATA_W-1:0]         o_tx_data,
    output logic                           o_tx_start,
    input  logic                           i_tx_done,
    output logic                           o_busy,
    output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
    output logic                           o_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = clog2Min1(TIMEOUT_CLKS + 1);
    localparam int GAP_W = clog2Min1(GAP_CLKS + 1);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CLKS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    // With no gap configured the end of a frame returns straight to IDLE.
    localparam tx_state_e AFTER_FRAME = (GAP_CLKS > 0) ? GAP : IDLE;

    tx_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [UART_DATA_W-1:0] txData_q, txData_d;
    logic                   txStart_q, txStart_d;
    logic                   busy_q, busy_d;
    logic [IDX_W-1:0]       grantId_q, grantId_d;
    logic                   timeout_q, timeout_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic [NUM_REQ-1:0]     winGrant;
    logic [IDX_W-1:0]       winIndex;
    logic                   winAny;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (i_req),
        .last_i  (last_q),
        .grant_o (winGrant),
        .index_o (winIndex),
        .any_o   (winAny)
    );

    // State register plus every output and counter. All outputs come straight
    // from flops. The round-robin pointer resets to the top index so that
    // requester 0 is first in line after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ack_q     <= '0;
            txData_q  <= '0;
            txStart_q <= 1'b0;
            busy_q    <= 1'b0;
            grantId_q <= '0;
            timeout_q <= 1'b0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            wdog_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            txData_q  <= txData_d;
            txStart_q <= txStart_d;
            busy_q    <= busy_d;
            grantId_q <= grantId_d;
            timeout_q <= timeout_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state and next-output logic. Pulses (ack, start, timeout) default
    // low so they only last the single cycle after the transition that sets
    // them; latched values default to holding.
    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        txStart_d = 1'b0;
        timeout_d = 1'b0;
        txData_d  = txData_q;
        grantId_d = grantId_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;

        case (state_q)
            IDLE: begin
                if (winAny) begin
                    txData_d  = i_data[UART_DATA_W*int'(winIndex) +: UART_DATA_W];
                    grantId_d = winIndex;
                    last_d    = winIndex;
                    ack_d     = winGrant;
                    txStart_d = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done takes priority over an expiring watchdog in the same cycle.
                wdog_d = wdog_q + 1'b1;
                if (i_tx_done) begin
                    gap_d   = '0;
                    state_d = AFTER_FRAME;
                end else if (wdog_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    gap_d     = '0;
                    state_d   = AFTER_FRAME;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign o_ack      = ack_q;
    assign o_tx_data  = txData_q;
    assign o_tx_start = txStart_q;
    assign o_busy     = busy_q;
    assign o_grant_id = grantId_q;
    assign o_timeout  = timeout_q;

endmodule
